q2_panel: RTL and testbench
===========================

# q2_panel

Front-panel controller for the q2 12-bit machine. It conditions the raw panel buttons and owns the memory bus while the CPU is halted. It sequences load-address, deposit and examine cycles against memory, and hands the bus to the CPU for run and single-step. It sits between the panel switches, the CPU run/idle controls and the external 12-bit memory.

## Interface
Parameters:
- DEBOUNCE_CYCLES, default 1000: consecutive stable cycles required before a button change is accepted (range 2..65535).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- sw  in  12  data/address switches, treated as static while a button is pressed.
- ld_raw, dep_raw, exam_raw, start_raw, stop_raw, step_raw  in  1 each  raw buttons, asynchronous, active-high.
- cpu_idle  in  1  CPU is at an instruction boundary.
- cpu_halt  in  1  CPU executed a self-jump ("jmp $"); level.
- cpu_run  out  1  CPU enable.
- bus_own  out  1  panel drives the memory bus; the CPU must tristate.
- mem_addr  out  12  memory address; valid when bus_own=1.
- mem_wdata  out  12  write data; equals the sampled sw value.
- mem_wr  out  1  one-cycle write strobe.
- mem_rd  out  1  one-cycle read strobe.
- mem_rdata  in  12  read data, valid the cycle after mem_rd.
- disp_addr  out  12  current panel address register.
- disp_data  out  12  last examined or deposited word.

## Operation
Each button passes through a 2-flop synchronizer, a debouncer and a rising-edge detector. The result is a 1-cycle event: ld_ev, dep_ev, exam_ev, start_ev, stop_ev or step_ev.

FSM states: HALT, WR, RD, RDCAP, HANDOFF, RUN, STOPW, STEP, STEPW.

HALT (bus_own=1, cpu_run=0) acts on events with priority start > step > ld > dep > exam. Lower-priority events in the same cycle are dropped.
- ld_ev: addr <= sw; disp_data unchanged; stay in HALT.
- dep_ev: go to WR, with mem_wdata and disp_data <= sw.
- exam_ev: go to RD.
- start_ev: go to HANDOFF, then RUN.
- step_ev: go to HANDOFF, then STEP.
- stop_ev: no-op.

Memory cycles:
- WR: mem_wr=1, mem_addr=addr. On exit, addr <= addr+1 and the FSM returns to HALT.
- RD: mem_rd=1, then go to RDCAP.
- RDCAP: disp_data <= mem_rdata, addr <= addr+1, return to HALT.

Bus handover and running:
- HANDOFF: bus_own=0 and cpu_run=0 for exactly 1 cycle (bus turnaround).
- RUN: cpu_run=1.
  - stop_ev: go to STOPW.
  - cpu_halt=1: go straight to HALT.
- STOPW: cpu_run stays 1 until cpu_idle=1. Then cpu_run=0 and the FSM moves to HALT; bus_own returns to 1 on the cycle after cpu_run falls.
- STEP: cpu_run=1 for 1 cycle, then go to STEPW.
- STEPW: cpu_run=1 until cpu_idle=1, then go to HALT.

Arithmetic and event handling:
- addr arithmetic is modulo 4096: 0xFFF+1 = 0x000.
- Events arriving outside HALT are discarded, except stop_ev in RUN; they are not queued.

## Timing
- Reset values:
  - state HALT, addr 0, disp_data 0, mem_wdata 0.
  - cpu_run 0, bus_own 1, mem_wr 0, mem_rd 0.
  - all debounced levels 0; no event is generated by reset release.
- Event latency: between DEBOUNCE_CYCLES+2 and DEBOUNCE_CYCLES+4 cycles after a raw edge. A raw bounce shorter than DEBOUNCE_CYCLES generates no event.
- Deposit: event at cycle n; mem_wr=1 in cycle n+1; addr shows A+1 at n+2.
- Examine: event at cycle n; mem_rd=1 at n+1; disp_data valid and addr=A+1 at n+3.
- Start: event at cycle n; bus_own=0 at n+1; cpu_run=1 at n+2.
- Stop with cpu_idle already 1: cpu_run=0 two cycles after stop_ev; bus_own=1 one cycle after that.
- rst mid-operation (including during WR or RUN) forces the reset values immediately. A partially issued mem_wr is truncated.

## Configuration
- Q2_PANEL_DEBOUNCE_EN defined: debouncer as above; DEBOUNCE_CYCLES is used.
- Not defined:
  - The synchronizer output feeds the edge detector directly.
  - Event latency is 3 cycles.
  - DEBOUNCE_CYCLES is ignored and no counter is built.

## Test plan
- Reset, then sw=0x123, ld, sw=0x7AB, dep: expect mem_wr with mem_addr=0x123 and mem_wdata=0x7AB, then disp_addr=0x124.
- ld 0xFFF, deposit twice: expect writes to 0xFFF then 0x000; disp_addr=0x001.
- Preload mem[0x040]=0x5A5, ld 0x040, exam: expect disp_data=0x5A5 on the 3rd cycle after the event, disp_addr=0x041.
- start, then cpu_idle=0 for 10 cycles, stop_raw, cpu_idle=1: expect cpu_run held until cpu_idle, cpu_run=0 and then bus_own=1, with no cycle where both bus_own=1 and cpu_run=1. Separately, from RUN, cpu_halt=1: expect HALT with bus_own=1.
- With Q2_PANEL_DEBOUNCE_EN and DEBOUNCE_CYCLES=8:
  - dep_raw pulses of 5 cycles produce no write.
  - dep and exam asserted together produce only a write.
  - dep during RUN is ignored.
- Assert rst during WR and during STEPW: expect all outputs at their reset values asynchronously, and the FSM in HALT after release.

Source files
------------

// File: rtl/q2_panel_if.sv
// q2_panel memory bus interface.
// The panel is the master while it owns the bus; memory is the slave.
interface q2_panel_if;
    logic        bus_own;
    logic [11:0] mem_addr;
    logic [11:0] mem_wdata;
    logic        mem_wr;
    logic        mem_rd;
    logic [11:0] mem_rdata;

    modport master (
        output bus_own, mem_addr, mem_wdata, mem_wr, mem_rd,
        input  mem_rdata
    );

    modport slave (
        input  bus_own, mem_addr, mem_wdata, mem_wr, mem_rd,
        output mem_rdata
    );
endinterface

// File: rtl/q2_panel.sv
// q2_panel: front-panel controller for the q2 12-bit machine.
// Conditions six raw buttons into 1-cycle events, runs load/deposit/examine
// cycles while the CPU is halted and hands the bus to the CPU for run/step.
// Build option: define Q2_PANEL_DEBOUNCE_EN to insert a DEBOUNCE_CYCLES
// debouncer between each synchronizer and its edge detector.
module q2_panel #(
    parameter int DEBOUNCE_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] i_sw,
    input  logic        i_ld_raw,
    input  logic        i_dep_raw,
    input  logic        i_exam_raw,
    input  logic        i_start_raw,
    input  logic        i_stop_raw,
    input  logic        i_step_raw,
    input  logic        i_cpu_idle,
    input  logic        i_cpu_halt,
    output logic        o_cpu_run,
    output logic [11:0] o_disp_addr,
    output logic [11:0] o_disp_data,
    q2_panel_if.master  bus
);

`ifdef Q2_PANEL_DEBOUNCE_EN
    localparam logic [15:0] DB_LAST = 16'(DEBOUNCE_CYCLES - 1);
`else
    // The parameter has no effect without the debouncer.
    localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;
`endif

    typedef enum logic [3:0] {
        S_HALT, S_WR, S_RD, S_RDCAP, S_HANDOFF, S_RUN, S_STOPW, S_STEP, S_STEPW
    } state_t;

    // Button order: 0 ld, 1 dep, 2 exam, 3 start, 4 stop, 5 step.
    logic [5:0] w_raw;
    logic [5:0] w_ev;

    assign w_raw = {i_step_raw, i_stop_raw, i_start_raw, i_exam_raw, i_dep_raw, i_ld_raw};

    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_btn
            logic [1:0] r_sync;
            logic       w_level;
            logic       r_level_d;
            logic       r_ev;

            // Two-flop synchronizer for the asynchronous button.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) r_sync <= 2'b00;
                else     r_sync <= {r_sync[0], w_raw[gi]};
            end

`ifdef Q2_PANEL_DEBOUNCE_EN
            logic [15:0] r_cnt;
            logic        r_level;

            // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_cnt   <= 16'd0;
                    r_level <= 1'b0;
                end else if (r_sync[1] == r_level) begin
                    r_cnt <= 16'd0;
                end else if (r_cnt == DB_LAST) begin
                    r_level <= r_sync[1];
                    r_cnt   <= 16'd0;
                end else begin
                    r_cnt <= r_cnt + 16'd1;
                end
            end

            assign w_level = r_level;
`else
            assign w_level = r_sync[1];
`endif

            // Registered rising-edge detector producing the 1-cycle event.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_level_d <= 1'b0;
                    r_ev      <= 1'b0;
                end else begin
                    r_level_d <= w_level;
                    r_ev      <= w_level & ~r_level_d;
                end
            end

            assign w_ev[gi] = r_ev;
        end
    endgenerate

    logic w_ld_ev, w_dep_ev, w_exam_ev, w_start_ev, w_stop_ev, w_step_ev;
    assign w_ld_ev    = w_ev[0];
    assign w_dep_ev   = w_ev[1];
    assign w_exam_ev  = w_ev[2];
    assign w_start_ev = w_ev[3];
    assign w_stop_ev  = w_ev[4];
    assign w_step_ev  = w_ev[5];

    state_t      r_state;
    logic        r_step_sel;   // HANDOFF leads to STEP rather than RUN
    logic [11:0] r_addr;
    logic [11:0] r_disp_data;
    logic [11:0] r_wdata;
    logic        r_cpu_run;
    logic        r_bus_own;
    logic        r_mem_wr;
    logic        r_mem_rd;

    // Panel FSM with registered outputs; bus_own only rises one cycle after
    // cpu_run falls because HALT re-asserts it on its own first clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_HALT;
            r_step_sel  <= 1'b0;
            r_addr      <= 12'h000;
            r_disp_data <= 12'h000;
            r_wdata     <= 12'h000;
            r_cpu_run   <= 1'b0;
            r_bus_own   <= 1'b1;
            r_mem_wr    <= 1'b0;
            r_mem_rd    <= 1'b0;
        end else begin
            r_mem_wr <= 1'b0;
            r_mem_rd <= 1'b0;
            case (r_state)
                S_HALT: begin
                    r_bus_own <= 1'b1;
                    r_cpu_run <= 1'b0;
                    if (w_start_ev) begin
                        r_state    <= S_HANDOFF;
                        r_step_sel <= 1'b0;
                        r_bus_own  <= 1'b0;
                    end else if (w_step_ev) begin
                        r_state    <= S_HANDOFF;
                        r_step_sel <= 1'b1;
                        r_bus_own  <= 1'b0;
                    end else if (w_ld_ev) begin
                        r_addr <= i_sw;
                    end else if (w_dep_ev) begin
                        r_state     <= S_WR;
                        r_mem_wr    <= 1'b1;
                        r_wdata     <= i_sw;
                        r_disp_data <= i_sw;
                    end else if (w_exam_ev) begin
                        r_state  <= S_RD;
                        r_mem_rd <= 1'b1;
                    end
                end
                S_WR: begin
                    r_addr  <= r_addr + 12'd1;
                    r_state <= S_HALT;
                end
                S_RD: begin
                    r_state <= S_RDCAP;
                end
                S_RDCAP: begin
                    r_disp_data <= bus.mem_rdata;
                    r_addr      <= r_addr + 12'd1;
                    r_state     <= S_HALT;
                end
                S_HANDOFF: begin
                    r_cpu_run <= 1'b1;
                    r_state   <= r_step_sel ? S_STEP : S_RUN;
                end
                S_RUN: begin
                    if (i_cpu_halt) begin
                        r_cpu_run <= 1'b0;
                        r_state   <= S_HALT;
                    end else if (w_stop_ev) begin
                        r_state <= S_STOPW;
                    end
                end
                S_STOPW, S_STEPW: begin
                    if (i_cpu_idle) begin
                        r_cpu_run <= 1'b0;
                        r_state   <= S_HALT;
                    end
                end
                S_STEP: begin
                    r_state <= S_STEPW;
                end
                default: begin
                    r_cpu_run <= 1'b0;
                    r_state   <= S_HALT;
                end
            endcase
        end
    end

    assign o_cpu_run     = r_cpu_run;
    assign o_disp_addr   = r_addr;
    assign o_disp_data   = r_disp_data;
    assign bus.bus_own   = r_bus_own;
    assign bus.mem_addr  = r_addr;
    assign bus.mem_wdata = r_wdata;
    assign bus.mem_wr    = r_mem_wr;
    assign bus.mem_rd    = r_mem_rd;

endmodule

// File: tb/tb_q2_panel.sv
// Testbench for q2_panel: scoreboard of expected writes/reads, memory model,
// and scenario tasks for load, deposit, examine, run/stop, step and reset.
module tb_q2_panel;
    localparam int D = 8;
`ifdef Q2_PANEL_DEBOUNCE_EN
    localparam int LAT_LO = D + 3;   // raw edge to first mem_wr sample
    localparam int LAT_HI = D + 5;
`else
    localparam int LAT_LO = 4;
    localparam int LAT_HI = 4;
`endif
    localparam int SETTLE   = D + 12;
    localparam int WAIT_MAX = D + 40;

    localparam int W_WR      = 0;
    localparam int W_RD      = 1;
    localparam int W_BUSFREE = 2;
    localparam int W_RUN     = 3;
    localparam int W_STOPPED = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [11:0] sw = 12'h000;
    logic [5:0]  raw = 6'b0;   // {step, stop, start, exam, dep, ld}
    logic        cpu_idle = 1'b0;
    logic        cpu_halt = 1'b0;
    logic        cpu_run;
    logic [11:0] disp_addr;
    logic [11:0] disp_data;

    q2_panel_if bus ();

    q2_panel #(.DEBOUNCE_CYCLES(D)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_sw        (sw),
        .i_ld_raw    (raw[0]),
        .i_dep_raw   (raw[1]),
        .i_exam_raw  (raw[2]),
        .i_start_raw (raw[3]),
        .i_stop_raw  (raw[4]),
        .i_step_raw  (raw[5]),
        .i_cpu_idle  (cpu_idle),
        .i_cpu_halt  (cpu_halt),
        .o_cpu_run   (cpu_run),
        .o_disp_addr (disp_addr),
        .o_disp_data (disp_data),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    // Memory model: write on mem_wr, read data registered one cycle after mem_rd.
    logic [11:0] mem [0:4095];
    always @(posedge clk) begin
        if (rst) mem[12'h040] <= 12'h5A5;
        else if (bus.mem_wr) mem[bus.mem_addr] <= bus.mem_wdata;
    end
    always @(posedge clk) begin
        if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr];
    end

    // Passive monitors.
    int wr_count = 0;
    int rd_count = 0;
    bit overlap_seen = 1'b0;
    always @(posedge clk) begin
        if (!rst && bus.mem_wr) wr_count++;
        if (!rst && bus.mem_rd) rd_count++;
    end
    always @(negedge clk) begin
        if (!rst && bus.bus_own && cpu_run) overlap_seen = 1'b1;
    end

    typedef struct packed {
        logic [11:0] addr;
        logic [11:0] data;
    } wr_t;

    wr_t         exp_wr[$];
    logic [11:0] exp_rd[$];
    int          total = 0;
    int          bad = 0;

    function automatic bit cond_now(input int which);
        case (which)
            W_WR:      return bus.mem_wr === 1'b1;
            W_RD:      return bus.mem_rd === 1'b1;
            W_BUSFREE: return bus.bus_own === 1'b0;
            W_RUN:     return cpu_run === 1'b1;
            default:   return cpu_run === 1'b0;
        endcase
    endfunction

    // Wait (bounded) for a DUT condition; lat = negedge count, -1 on timeout.
    task automatic await_cond(input int which, output int lat);
        lat = -1;
        for (int i = 1; i <= WAIT_MAX; i++) begin
            @(negedge clk);
            if (cond_now(which)) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic settle();
        repeat (SETTLE) @(negedge clk);
    endtask

    task automatic tap(input int b);
        raw[b] = 1'b1;
        settle();
        raw[b] = 1'b0;
        settle();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({cpu_run, bus.bus_own, bus.mem_wr, bus.mem_rd} !== 4'b0100) begin
            bad++;
            $display("FAIL reset_ctrl got=%b want=0100", {cpu_run, bus.bus_own, bus.mem_wr, bus.mem_rd});
        end
        total++;
        if ({disp_addr, disp_data, bus.mem_wdata} !== 36'h0) begin
            bad++;
            $display("FAIL reset_regs got=%h want=0", {disp_addr, disp_data, bus.mem_wdata});
        end
        rst = 1'b0;
        settle();
        total++;
        if (wr_count !== 0 || rd_count !== 0 || disp_addr !== 12'h000) begin
            bad++;
            $display("FAIL reset_release wr=%0d rd=%0d addr=%h want 0/0/000", wr_count, rd_count, disp_addr);
        end
        $display("test_reset done");
    endtask

    task automatic test_load_deposit();
        int  lat;
        wr_t e;
        sw = 12'h123;
        tap(0);
        total++;
        if (disp_addr !== 12'h123) begin bad++; $display("FAIL ld_addr got=%h want=123", disp_addr); end
        total++;
        if (disp_data !== 12'h000) begin bad++; $display("FAIL ld_data_kept got=%h want=000", disp_data); end
        sw = 12'h7AB;
        exp_wr.push_back({12'h123, 12'h7AB});
        raw[1] = 1'b1;
        await_cond(W_WR, lat);
        e = exp_wr.pop_front();
        total++;
        if (lat < 0) begin
            bad++; $display("FAIL dep_timeout no mem_wr within %0d cycles", WAIT_MAX);
        end else if ({bus.mem_addr, bus.mem_wdata} !== {e.addr, e.data}) begin
            bad++; $display("FAIL dep_write got=%h/%h want=%h/%h", bus.mem_addr, bus.mem_wdata, e.addr, e.data);
        end
        total++;
        if (lat < LAT_LO || lat > LAT_HI) begin
            bad++; $display("FAIL dep_latency got=%0d want=%0d..%0d", lat, LAT_LO, LAT_HI);
        end
        @(negedge clk);
        total++;
        if (bus.mem_wr !== 1'b0) begin bad++; $display("FAIL wr_one_cycle got=%b want=0", bus.mem_wr); end
        total++;
        if (disp_addr !== 12'h124) begin bad++; $display("FAIL dep_addr_inc got=%h want=124", disp_addr); end
        total++;
        if (disp_data !== 12'h7AB) begin bad++; $display("FAIL dep_disp_data got=%h want=7AB", disp_data); end
        raw[1] = 1'b0;
        settle();
        $display("test_load_deposit done");
    endtask

    task automatic test_wrap();
        int          lat;
        wr_t         e;
        logic [11:0] vals [2];
        logic [11:0] addrs [2];
        vals[0] = 12'h111; vals[1] = 12'h222;
        addrs[0] = 12'hFFF; addrs[1] = 12'h000;
        sw = 12'hFFF;
        tap(0);
        for (int k = 0; k < 2; k++) begin
            sw = vals[k];
            exp_wr.push_back({addrs[k], vals[k]});
            raw[1] = 1'b1;
            await_cond(W_WR, lat);
            e = exp_wr.pop_front();
            total++;
            if (lat < 0 || {bus.mem_addr, bus.mem_wdata} !== {e.addr, e.data}) begin
                bad++; $display("FAIL wrap_write%0d lat=%0d got=%h/%h want=%h/%h", k, lat, bus.mem_addr, bus.mem_wdata, e.addr, e.data);
            end
            raw[1] = 1'b0;
            settle();
        end
        total++;
        if (disp_addr !== 12'h001) begin bad++; $display("FAIL wrap_addr got=%h want=001", disp_addr); end
        $display("test_wrap done");
    endtask

    task automatic test_examine();
        int          lat;
        logic [11:0] e;
        sw = 12'h040;
        tap(0);
        exp_rd.push_back(12'h5A5);
        raw[2] = 1'b1;
        await_cond(W_RD, lat);
        total++;
        if (lat < 0 || bus.mem_addr !== 12'h040) begin
            bad++; $display("FAIL exam_rd lat=%0d addr=%h want addr=040", lat, bus.mem_addr);
        end
        repeat (2) @(negedge clk);
        e = exp_rd.pop_front();
        total++;
        if (disp_data !== e) begin bad++; $display("FAIL exam_data got=%h want=%h", disp_data, e); end
        total++;
        if (disp_addr !== 12'h041) begin bad++; $display("FAIL exam_addr got=%h want=041", disp_addr); end
        raw[2] = 1'b0;
        settle();
        $display("test_examine done");
    endtask

    task automatic test_run_stop();
        int lat;
        int n0;
        cpu_idle = 1'b0;
        raw[3] = 1'b1;
        await_cond(W_BUSFREE, lat);
        total++;
        if (lat < 0 || cpu_run !== 1'b0) begin bad++; $display("FAIL start_handoff lat=%0d run=%b want run=0", lat, cpu_run); end
        @(negedge clk);
        total++;
        if (cpu_run !== 1'b1 || bus.bus_own !== 1'b0) begin
            bad++; $display("FAIL start_run run=%b own=%b want 1/0", cpu_run, bus.bus_own);
        end
        raw[3] = 1'b0;
        settle();
        n0 = wr_count;
        tap(1);
        total++;
        if (wr_count !== n0 || cpu_run !== 1'b1) begin
            bad++; $display("FAIL dep_in_run writes=%0d want=%0d run=%b", wr_count, n0, cpu_run);
        end
        raw[4] = 1'b1;
        repeat (30) @(negedge clk);
        total++;
        if (cpu_run !== 1'b1) begin bad++; $display("FAIL stopw_hold run=%b want=1", cpu_run); end
        cpu_idle = 1'b1;
        await_cond(W_STOPPED, lat);
        total++;
        if (lat !== 1 || bus.bus_own !== 1'b0) begin
            bad++; $display("FAIL stop_on_idle lat=%0d own=%b want 1/0", lat, bus.bus_own);
        end
        @(negedge clk);
        total++;
        if (bus.bus_own !== 1'b1) begin bad++; $display("FAIL stop_bus_back got=%b want=1", bus.bus_own); end
        raw[4] = 1'b0;
        settle();
        // Restart and stop again with cpu_idle already high.
        raw[3] = 1'b1;
        await_cond(W_RUN, lat);
        raw[3] = 1'b0;
        settle();
        raw[4] = 1'b1;
        await_cond(W_STOPPED, lat);
        total++;
        if (lat < LAT_LO + 1 || lat > LAT_HI + 1) begin
            bad++; $display("FAIL stop_idle_latency got=%0d want=%0d..%0d", lat, LAT_LO + 1, LAT_HI + 1);
        end
        @(negedge clk);
        total++;
        if (bus.bus_own !== 1'b1) begin bad++; $display("FAIL stop2_bus_back got=%b want=1", bus.bus_own); end
        raw[4] = 1'b0;
        cpu_idle = 1'b0;
        settle();
        $display("test_run_stop done");
    endtask

    task automatic test_cpu_halt();
        int lat;
        raw[3] = 1'b1;
        await_cond(W_RUN, lat);
        raw[3] = 1'b0;
        settle();
        total++;
        if (lat < 0 || cpu_run !== 1'b1) begin bad++; $display("FAIL halt_setup lat=%0d run=%b want run=1", lat, cpu_run); end
        cpu_halt = 1'b1;
        await_cond(W_STOPPED, lat);
        total++;
        if (lat !== 1) begin bad++; $display("FAIL halt_stop lat=%0d want=1", lat); end
        @(negedge clk);
        total++;
        if (bus.bus_own !== 1'b1) begin bad++; $display("FAIL halt_bus_back got=%b want=1", bus.bus_own); end
        cpu_halt = 1'b0;
        sw = 12'h2B0;
        tap(0);
        total++;
        if (disp_addr !== 12'h2B0) begin bad++; $display("FAIL halt_ld got=%h want=2B0", disp_addr); end
        $display("test_cpu_halt done");
    endtask

    task automatic test_debounce();
`ifdef Q2_PANEL_DEBOUNCE_EN
        int          n0;
        logic [11:0] a0;
        n0 = wr_count;
        a0 = disp_addr;
        repeat (3) begin
            raw[1] = 1'b1;
            repeat (5) @(negedge clk);
            raw[1] = 1'b0;
            repeat (5) @(negedge clk);
        end
        settle();
        total++;
        if (wr_count !== n0 || disp_addr !== a0) begin
            bad++; $display("FAIL bounce_write writes=%0d want=%0d addr=%h want=%h", wr_count, n0, disp_addr, a0);
        end
`endif
        $display("test_debounce done");
    endtask

    task automatic test_simultaneous();
        int  lat;
        int  r0;
        wr_t e;
        sw = 12'h300;
        tap(0);
        r0 = rd_count;
        sw = 12'h3C3;
        exp_wr.push_back({12'h300, 12'h3C3});
        raw[1] = 1'b1;
        raw[2] = 1'b1;
        await_cond(W_WR, lat);
        e = exp_wr.pop_front();
        total++;
        if (lat < 0 || {bus.mem_addr, bus.mem_wdata} !== {e.addr, e.data}) begin
            bad++; $display("FAIL dep_exam_write lat=%0d got=%h/%h want=%h/%h", lat, bus.mem_addr, bus.mem_wdata, e.addr, e.data);
        end
        raw[1] = 1'b0;
        raw[2] = 1'b0;
        settle();
        total++;
        if (rd_count !== r0 || disp_data !== 12'h3C3 || disp_addr !== 12'h301) begin
            bad++; $display("FAIL dep_exam_only reads=%0d want=%0d data=%h want=3C3 addr=%h want=301", rd_count, r0, disp_data, disp_addr);
        end
        $display("test_simultaneous done");
    endtask

    task automatic test_step();
        int lat;
        cpu_idle = 1'b0;
        raw[5] = 1'b1;
        await_cond(W_BUSFREE, lat);
        @(negedge clk);
        total++;
        if (lat < 0 || cpu_run !== 1'b1) begin bad++; $display("FAIL step_run lat=%0d run=%b want run=1", lat, cpu_run); end
        repeat (4) @(negedge clk);
        total++;
        if (cpu_run !== 1'b1) begin bad++; $display("FAIL stepw_hold run=%b want=1", cpu_run); end
        raw[5] = 1'b0;
        cpu_idle = 1'b1;
        await_cond(W_STOPPED, lat);
        @(negedge clk);
        total++;
        if (lat !== 1 || bus.bus_own !== 1'b1) begin
            bad++; $display("FAIL step_done lat=%0d own=%b want 1/1", lat, bus.bus_own);
        end
        cpu_idle = 1'b0;
        settle();
        $display("test_step done");
    endtask

    task automatic test_reset_mid();
        int  lat;
        int  n0;
        wr_t e;
        // Reset during WR.
        n0 = wr_count;
        sw = 12'h0F0;
        raw[1] = 1'b1;
        await_cond(W_WR, lat);
        rst = 1'b1;
        #1;
        total++;
        if (lat < 0 || {cpu_run, bus.bus_own, bus.mem_wr, bus.mem_rd} !== 4'b0100) begin
            bad++; $display("FAIL rst_in_wr lat=%0d ctrl=%b want=0100", lat, {cpu_run, bus.bus_own, bus.mem_wr, bus.mem_rd});
        end
        total++;
        if ({disp_addr, disp_data, bus.mem_wdata} !== 36'h0) begin
            bad++; $display("FAIL rst_in_wr_regs got=%h want=0", {disp_addr, disp_data, bus.mem_wdata});
        end
        raw = 6'b0;
        settle();
        rst = 1'b0;
        settle();
        total++;
        if (wr_count !== n0) begin bad++; $display("FAIL rst_truncates_wr writes=%0d want=%0d", wr_count, n0); end
        // Reset during STEPW.
        cpu_idle = 1'b0;
        raw[5] = 1'b1;
        await_cond(W_RUN, lat);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        total++;
        if (lat < 0 || cpu_run !== 1'b0 || bus.bus_own !== 1'b1) begin
            bad++; $display("FAIL rst_in_stepw lat=%0d run=%b own=%b want 0/1", lat, cpu_run, bus.bus_own);
        end
        raw = 6'b0;
        settle();
        rst = 1'b0;
        settle();
        // Back in HALT with addr 0: a deposit must land at 0x000.
        sw = 12'h055;
        exp_wr.push_back({12'h000, 12'h055});
        raw[1] = 1'b1;
        await_cond(W_WR, lat);
        e = exp_wr.pop_front();
        total++;
        if (lat < 0 || {bus.mem_addr, bus.mem_wdata} !== {e.addr, e.data}) begin
            bad++; $display("FAIL post_rst_dep lat=%0d got=%h/%h want=%h/%h", lat, bus.mem_addr, bus.mem_wdata, e.addr, e.data);
        end
        raw[1] = 1'b0;
        settle();
        $display("test_reset_mid done");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load_deposit();
        test_wrap();
        test_examine();
        test_run_stop();
        test_cpu_halt();
        test_debounce();
        test_simultaneous();
        test_step();
        test_reset_mid();
        total++;
        if (overlap_seen !== 1'b0) begin bad++; $display("FAIL bus_run_overlap got=%b want=0", overlap_seen); end
        total++;
        if (exp_wr.size() != 0 || exp_rd.size() != 0) begin
            bad++; $display("FAIL scoreboard_left wr=%0d rd=%0d want 0/0", exp_wr.size(), exp_rd.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
